// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared pong display constants, direction encoding and axis step helper
package pong_pkg;

  localparam int              H_ACTIVE_DEF = 640;
  localparam int              V_ACTIVE_DEF = 480;
  localparam int              CW_DEF       = 4;
  localparam logic [11:0]     FG_RGB_DEF   = 12'hF0F;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

  typedef struct packed {
    logic [9:0] pos;
    dir_e       dir;
    logic       hit;
  } axis_t;

  function automatic dir_e flip_dir(input dir_e dir);
    return (dir == DIR_POS) ? DIR_NEG : DIR_POS;
  endfunction

  // One frame step on one axis; 11-bit arithmetic so pos+speed never wraps.
  function automatic axis_t axis_step(input logic [9:0]  pos,
                                      input dir_e        dir,
                                      input logic [10:0] speed,
                                      input logic [10:0] max_pos);
    axis_t r;
    r.pos = pos;
    r.dir = dir;
    r.hit = 1'b0;
    if (dir == DIR_POS) begin
      if (({1'b0, pos} + speed) >= max_pos) begin
        r.pos = max_pos[9:0];
        r.dir = DIR_NEG;
        r.hit = 1'b1;
      end else begin
        r.pos = pos + speed[9:0];
      end
    end else begin
      if ({1'b0, pos} <= speed) begin
        r.pos = '0;
        r.dir = DIR_POS;
        r.hit = 1'b1;
      end else begin
        r.pos = pos - speed[9:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ball_motion.sv
// rtl/ball_motion.sv - ball position, direction, paddle bounce request and wall-hit pulse
module ball_motion
  import pong_pkg::*;
#(
  parameter int XMAX   = 632,
  parameter int YMAX   = 472,
  parameter int X_INIT = 300,
  parameter int Y_INIT = 400,
  parameter int SPEED  = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic       bounce_x,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       edge_hit
);

  localparam logic [10:0] SPD = 11'(SPEED);
  localparam logic [10:0] XM  = 11'(XMAX);
  localparam logic [10:0] YM  = 11'(YMAX);

  logic [9:0] x_q, x_d, y_q, y_d;
  dir_e       dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic       pend_q, pend_d, edge_q, edge_d;
  axis_t      xs_wall, xs_bnc, xs, ys;

  always_comb begin
    xs_wall = axis_step(x_q, dir_x_q, SPD, XM);
    xs_bnc  = axis_step(x_q, flip_dir(dir_x_q), SPD, XM);
    // A wall bounce on the current direction overrides the paddle request.
    xs      = ((pend_q || bounce_x) && !xs_wall.hit) ? xs_bnc : xs_wall;
    ys      = axis_step(y_q, dir_y_q, SPD, YM);

    x_d     = x_q;
    y_d     = y_q;
    dir_x_d = dir_x_q;
    dir_y_d = dir_y_q;
    pend_d  = pend_q | bounce_x;
    edge_d  = 1'b0;
    if (frame_tick && enable) begin
      x_d     = xs.pos;
      y_d     = ys.pos;
      dir_x_d = xs.dir;
      dir_y_d = ys.dir;
      pend_d  = 1'b0;
      edge_d  = xs.hit | ys.hit;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= 10'(X_INIT);
      y_q     <= 10'(Y_INIT);
      dir_x_q <= DIR_POS;
      dir_y_q <= DIR_POS;
      pend_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      dir_x_q <= dir_x_d;
      dir_y_q <= dir_y_d;
      pend_q  <= pend_d;
      edge_q  <= edge_d;
    end
  end

  assign ball_x   = x_q;
  assign ball_y   = y_q;
  assign edge_hit = edge_q;

endmodule

// File: rtl/ball_sprite_engine.sv
// rtl/ball_sprite_engine.sv - bouncing bitmap ball: motion plus 2-cycle sprite render pipeline
module ball_sprite_engine
  import pong_pkg::*;
#(
  parameter int              H_ACTIVE = H_ACTIVE_DEF,
  parameter int              V_ACTIVE = V_ACTIVE_DEF,
  parameter int              SPR_SIZE = 8,
  parameter int              SPR_AW   = 3,
  parameter int              X_INIT   = 300,
  parameter int              Y_INIT   = 400,
  parameter int              SPEED    = 1,
  parameter int              CW       = CW_DEF,
  parameter logic [3*CW-1:0] FG_RGB   = (3*CW)'(FG_RGB_DEF)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [9:0]          x_pos,
  input  logic [9:0]          y_pos,
  input  logic                video_on,
  input  logic                frame_tick,
  input  logic                enable,
  input  logic                bounce_x,
  output logic [SPR_AW-1:0]   spr_addr,
  input  logic [SPR_SIZE-1:0] spr_data,
  output logic [CW-1:0]       red,
  output logic [CW-1:0]       green,
  output logic [CW-1:0]       blue,
  output logic [9:0]          ball_x,
  output logic [9:0]          ball_y,
  output logic                edge_hit
);

  logic [SPR_AW-1:0] spr_addr_q, spr_addr_d, col_q, col_d;
  logic              vld1_q, vld1_d;
  logic [3*CW-1:0]   rgb_q, rgb_d;
  logic [10:0]       dx, dy;
  logic              in_x, in_y;

  ball_motion #(
    .XMAX  (H_ACTIVE - SPR_SIZE),
    .YMAX  (V_ACTIVE - SPR_SIZE),
    .X_INIT(X_INIT),
    .Y_INIT(Y_INIT),
    .SPEED (SPEED)
  ) u_motion (
    .clk       (clk),
    .reset     (reset),
    .frame_tick(frame_tick),
    .enable    (enable),
    .bounce_x  (bounce_x),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .edge_hit  (edge_hit)
  );

  // The spr_addr register doubles as the ROM address register, so spr_data lines up with vld1/col.
  always_comb begin
    dx         = {1'b0, x_pos} - {1'b0, ball_x};
    dy         = {1'b0, y_pos} - {1'b0, ball_y};
    in_x       = (x_pos >= ball_x) && (dx < 11'(SPR_SIZE));
    in_y       = (y_pos >= ball_y) && (dy < 11'(SPR_SIZE));
    spr_addr_d = dy[SPR_AW-1:0];
    col_d      = dx[SPR_AW-1:0];
    vld1_d     = video_on & in_x & in_y;
    rgb_d      = (vld1_q && spr_data[col_q]) ? FG_RGB : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spr_addr_q <= '0;
      col_q      <= '0;
      vld1_q     <= 1'b0;
      rgb_q      <= '0;
    end else begin
      spr_addr_q <= spr_addr_d;
      col_q      <= col_d;
      vld1_q     <= vld1_d;
      rgb_q      <= rgb_d;
    end
  end

  assign spr_addr = spr_addr_q;
  assign red      = rgb_q[3*CW-1 -: CW];
  assign green    = rgb_q[2*CW-1 -: CW];
  assign blue     = rgb_q[CW-1:0];

endmodule

// File: tb/tb_ball_sprite_engine.sv
// tb/tb_ball_sprite_engine.sv - scoreboard bench for ball_sprite_engine motion and rendering
module tb_ball_sprite_engine;

  logic       clk, reset, video_on, frame_tick, enable, bounce_x;
  logic [9:0] x_pos, y_pos, ball_x, ball_y;
  logic [2:0] spr_addr;
  logic [7:0] spr_data;
  logic [3:0] red, green, blue;
  logic       edge_hit;

  logic [7:0] rom [8];
  assign spr_data = rom[spr_addr];

  ball_sprite_engine dut (
    .clk(clk), .reset(reset), .x_pos(x_pos), .y_pos(y_pos), .video_on(video_on),
    .frame_tick(frame_tick), .enable(enable), .bounce_x(bounce_x),
    .spr_addr(spr_addr), .spr_data(spr_data), .red(red), .green(green), .blue(blue),
    .ball_x(ball_x), .ball_y(ball_y), .edge_hit(edge_hit)
  );

  typedef struct {int x; int y; bit e;} mot_t;
  mot_t        mq[$];
  logic [11:0] pq[$];
  int mx, my;
  bit mdx, mdy, mpend;
  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // d: 0 = moving positive, 1 = moving negative
  function automatic void mstep(input int p, input bit d, input int lim,
                                output int np, output bit nd, output bit hit);
    np = p; nd = d; hit = 1'b0;
    if (!d) begin
      if (p + 1 >= lim) begin np = lim; nd = 1'b1; hit = 1'b1; end
      else np = p + 1;
    end else begin
      if (p <= 1) begin np = 0; nd = 1'b0; hit = 1'b1; end
      else np = p - 1;
    end
  endfunction

  task automatic model_tick();
    int nx, ny;
    bit ndx, ndy, hx, hy;
    mstep(mx, mdx, 632, nx, ndx, hx);
    if (mpend && !hx) mstep(mx, !mdx, 632, nx, ndx, hx);
    mstep(my, mdy, 472, ny, ndy, hy);
    mx = nx; my = ny; mdx = ndx; mdy = ndy; mpend = 1'b0;
    mq.push_back('{mx, my, hx | hy});
  endtask

  task automatic tick(input logic en);
    mot_t e;
    @(negedge clk);
    frame_tick = 1'b1;
    enable     = en;
    if (en) model_tick();
    else    mq.push_back('{mx, my, 1'b0});
    @(negedge clk);
    frame_tick = 1'b0;
    enable     = 1'b1;
    e = mq.pop_front();
    check("ball_x", ball_x, e.x);
    check("ball_y", ball_y, e.y);
    check("edge_hit", edge_hit, e.e);
    @(negedge clk);
    check("edge_pulse", edge_hit, 0);
  endtask

  task automatic bounce();
    @(negedge clk);
    bounce_x = 1'b1;
    @(negedge clk);
    bounce_x = 1'b0;
    mpend = 1'b1;
  endtask

  task automatic pixel(input int x, input int y, input logic von);
    logic [9:0]  xp, yp;
    logic [7:0]  row;
    logic [11:0] e;
    int cx, cy;
    @(negedge clk);
    if (pq.size() == 2) check("rgb", {red, green, blue}, pq.pop_front());
    xp = 10'(x);
    yp = 10'(y);
    x_pos = xp; y_pos = yp; video_on = von;
    cx = int'(xp) - mx;
    cy = int'(yp) - my;
    e  = 12'h000;
    if (von && cx >= 0 && cx < 8 && cy >= 0 && cy < 8) begin
      row = rom[cy];
      if (row[cx]) e = 12'hF0F;
    end
    pq.push_back(e);
  endtask

  task automatic render_scan();
    for (int y = my - 2; y <= my + 9; y++)
      for (int x = mx - 2; x <= mx + 9; x++)
        pixel(x, y, ((x * 3 + y) & 7) != 0);
    pixel(0, 0, 1'b0);
    pixel(0, 0, 1'b0);
  endtask

  initial begin
    bit corner_done, t5a, t5b, done;
    int n;
    rom[0] = 8'b0011_1100; rom[1] = 8'b0111_1110; rom[2] = 8'b1111_1111; rom[3] = 8'b0000_0100;
    rom[4] = 8'b1111_1111; rom[5] = 8'b0111_1110; rom[6] = 8'b0011_1100; rom[7] = 8'b1000_0001;
    reset = 1'b1; video_on = 1'b0; frame_tick = 1'b0; enable = 1'b1; bounce_x = 1'b0;
    x_pos = '0; y_pos = '0;
    mx = 300; my = 400; mdx = 1'b0; mdy = 1'b0; mpend = 1'b0;
    #3;
    check("rst_ball_x", ball_x, 300);
    check("rst_ball_y", ball_y, 400);
    check("rst_rgb", {red, green, blue}, 0);
    check("rst_edge", edge_hit, 0);
    check("rst_spr_addr", spr_addr, 0);
    @(negedge clk);
    reset = 1'b0;

    pixel(302, 403, 1'b1);
    @(posedge clk);
    #1;
    check("spr_addr_row3", spr_addr, 3);
    pixel(308, 403, 1'b1);
    render_scan();

    repeat (3) tick(1'b1);
    check("t2_x", ball_x, 303);
    check("t2_y", ball_y, 403);
    tick(1'b0);

    corner_done = 1'b0; t5a = 1'b0; t5b = 1'b0; done = 1'b0; n = 0;
    while (!done && n < 4000) begin
      if (!corner_done && mx == my && mdx != mdy) bounce();
      if (corner_done && !t5a && mx == 100 && !mdx) begin
        bounce();
        tick(1'b0);
        t5a = 1'b1;
      end
      if (t5a && !t5b && mx == 631 && !mdx) begin
        bounce();
        t5b = 1'b1;
      end else if (t5b && mx == 632) begin
        done = 1'b1;
      end
      tick(1'b1);
      n++;
      if (!corner_done && mx == 0 && my == 0) corner_done = 1'b1;
    end
    check("steer_done", done, 1);
    check("final_x", ball_x, 631);
    render_scan();

    @(negedge clk);
    x_pos = 10'(mx); y_pos = 10'(my + 2); video_on = 1'b1;
    bounce();
    repeat (3) @(negedge clk);
    check("rgb_pre_reset", {red, green, blue}, 12'hF0F);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_ball_x", ball_x, 300);
    check("mid_rst_ball_y", ball_y, 400);
    check("mid_rst_rgb", {red, green, blue}, 0);
    check("mid_rst_edge", edge_hit, 0);
    check("mid_rst_spr_addr", spr_addr, 0);
    @(negedge clk);
    video_on = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mx = 300; my = 400; mdx = 1'b0; mdy = 1'b0; mpend = 1'b0;
    tick(1'b1);
    render_scan();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
